// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT pipeline stage controllers.
package fft_pkg;

  localparam int unsigned FFT_N_LOG2 = 10;

  // Stage mode presented to the butterfly/delay-line datapath
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_BFLY = 2'd2
  } stage_state_e;

  // Delay-line length of a stage: D = N >> stage
  function automatic int unsigned stage_delay(input int unsigned stage,
                                              input int unsigned n_log2 = FFT_N_LOG2);
    return 32'd1 << (n_log2 - stage);
  endfunction

  // Twiddle index increment per sample of a stage
  function automatic int unsigned tw_step(input int unsigned stage);
    return 32'd1 << (stage - 1);
  endfunction

endpackage

// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF stage: frame position, stage mode, twiddle addressing.
module fft_sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned N_LOG2 = FFT_N_LOG2,
  parameter int unsigned STAGE  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              flush,
  input  logic              clr,
  output logic [1:0]        state,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              tw_en,
  output logic              out_valid,
  output logic              frame_done
);

  localparam int unsigned D = stage_delay(STAGE, N_LOG2);

  localparam logic [N_LOG2-1:0] PosMask = N_LOG2'(2 * D - 1);
  localparam logic [N_LOG2-1:0] DMask   = N_LOG2'(D - 1);
  localparam logic [N_LOG2-1:0] DVal    = N_LOG2'(D);
  localparam logic [N_LOG2-1:0] CntMax  = N_LOG2'((1 << N_LOG2) - 1);
  localparam logic [N_LOG2-1:0] TwStep  = N_LOG2'(tw_step(STAGE));

  logic [N_LOG2-1:0] cnt_q, cnt_d;
  logic              primed_q, primed_d;
  logic              frame_done_q, frame_done_d;

  logic              adv;
  logic [N_LOG2-1:0] pos;
  logic [N_LOG2-1:0] pos_mod_d;
  logic [N_LOG2-1:0] tw_full;
  logic              lower;
  stage_state_e      st;

  assign adv       = (in_valid | flush) & ~clr;
  assign pos       = cnt_q & PosMask;
  assign pos_mod_d = cnt_q & DMask;
  assign lower     = (pos < DVal);
  // Power-of-two constant multiply; reduces to a shift
  assign tw_full   = pos_mod_d * TwStep;

  // Next-state: advance on accepted/flushed sample, clr restarts, otherwise stall
  always_comb begin
    cnt_d        = cnt_q;
    primed_d     = primed_q;
    frame_done_d = 1'b0;
    if (clr) begin
      cnt_d    = '0;
      primed_d = 1'b0;
    end else if (adv) begin
      // Natural wrap from N-1 to 0
      cnt_d        = cnt_q + 1'b1;
      frame_done_d = (cnt_q == CntMax);
      if (!primed_q && (pos == DMask)) begin
        primed_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      primed_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      primed_q     <= primed_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Output decode for the sample presented this cycle
  always_comb begin
    st = ST_IDLE;
    if (!clr) begin
      if (!lower) begin
        st = ST_BFLY;
      end else if (primed_q) begin
        st = ST_FILL;
      end
    end
    state     = st;
    tw_addr   = (st == ST_FILL) ? tw_full[N_LOG2-2:0] : '0;
    tw_en     = adv & (st == ST_FILL);
    out_valid = adv & (st != ST_IDLE);
  end

  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Directed bench for fft_sdf_stage_ctrl: STAGE=2 (D=256) and STAGE=10 (D=1) instances.
module tb_fft_sdf_stage_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // STAGE=2 instance
  logic       iv2, fl2, cl2;
  logic [1:0] st2;
  logic [8:0] tw2;
  logic       en2, ov2, fd2;
  logic [13:0] obs2;
  assign obs2 = {st2, tw2, en2, ov2, fd2};

  fft_sdf_stage_ctrl #(.N_LOG2(10), .STAGE(2)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv2),
    .flush     (fl2),
    .clr       (cl2),
    .state     (st2),
    .tw_addr   (tw2),
    .tw_en     (en2),
    .out_valid (ov2),
    .frame_done(fd2)
  );

  // STAGE=10 instance
  logic       iv10, fl10, cl10;
  logic [1:0] st10;
  logic [8:0] tw10;
  logic       en10, ov10, fd10;
  logic [13:0] obs10;
  assign obs10 = {st10, tw10, en10, ov10, fd10};

  fft_sdf_stage_ctrl #(.N_LOG2(10), .STAGE(10)) u_s10 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iv10),
    .flush     (fl10),
    .clr       (cl10),
    .state     (st10),
    .tw_addr   (tw10),
    .tw_en     (en10),
    .out_valid (ov10),
    .frame_done(fd10)
  );

  // Expected {state, tw_addr, tw_en, out_valid, frame_done} for STAGE=2, k samples since reset/clr,
  // sample k being presented with in_valid high.
  function automatic logic [13:0] exp_s2(input int k);
    int p;
    logic [1:0] s;
    logic [8:0] t;
    logic fd;
    p  = (k % 1024) % 512;
    fd = (k > 0) && (k % 1024 == 0);
    if (k < 256)      s = 2'd0;
    else if (p < 256) s = 2'd1;
    else              s = 2'd2;
    t = (s == 2'd1) ? 9'(2 * p) : 9'd0;
    return {s, t, (s == 2'd1), (s != 2'd0), fd};
  endfunction

  // Same for STAGE=10: idle on the very first sample, then BFLY on odd, FILL on even positions
  function automatic logic [13:0] exp_s10(input int k);
    logic [1:0] s;
    logic fd;
    fd = (k > 0) && (k % 1024 == 0);
    if (k == 0)          s = 2'd0;
    else if (k % 2 == 1) s = 2'd2;
    else                 s = 2'd1;
    return {s, 9'd0, (s == 2'd1), (s != 2'd0), fd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iv2 = 0; fl2 = 0; cl2 = 0;
    iv10 = 0; fl10 = 0; cl10 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (obs2 !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_s2: got %h expected %h", obs2, 14'd0);
    end
    n_checks++;
    if (obs10 !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_s10: got %h expected %h", obs10, 14'd0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    // Still idle with no input after reset release
    n_checks++;
    if (obs2 !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_idle_s2: got %h expected %h", obs2, 14'd0);
    end
  endtask

  // Fill, butterfly, twiddle sweep, frame wrap and back-to-back second frame
  task automatic test_frames();
    do_reset();
    for (int k = 0; k < 1024 + 300; k++) begin
      iv2 = 1'b1;
      #2;
      n_checks++;
      if (obs2 !== exp_s2(k)) begin
        n_fail++;
        $display("FAIL frames_s2 k=%0d: got %h expected %h", k, obs2, exp_s2(k));
      end
      tick();
    end
    iv2 = 1'b0;
  endtask

  // Input gaps freeze position, state and tw_addr; outputs drop
  task automatic test_gaps();
    do_reset();
    for (int k = 0; k < 520; k++) begin
      iv2 = 1'b1;
      tick();
    end
    for (int g = 0; g < 3; g++) begin
      iv2 = 1'b0;
      #2;
      n_checks++;
      if (obs2 !== {2'd1, 9'd16, 1'b0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL gap g=%0d: got %h expected %h", g, obs2, {2'd1, 9'd16, 3'b000});
      end
      tick();
    end
    for (int k = 520; k < 530; k++) begin
      iv2 = 1'b1;
      #2;
      n_checks++;
      if (obs2 !== exp_s2(k)) begin
        n_fail++;
        $display("FAIL gap_resume k=%0d: got %h expected %h", k, obs2, exp_s2(k));
      end
      tick();
    end
    iv2 = 1'b0;
  endtask

  // clr with in_valid drops the sample and restarts the fill
  task automatic test_clr();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      iv2 = 1'b1;
      tick();
    end
    iv2 = 1'b1;
    cl2 = 1'b1;
    #2;
    n_checks++;
    if (obs2 !== 14'd0) begin
      n_fail++;
      $display("FAIL clr_cycle: got %h expected %h", obs2, 14'd0);
    end
    tick();
    cl2 = 1'b0;
    for (int j = 0; j < 260; j++) begin
      iv2 = 1'b1;
      #2;
      n_checks++;
      if (obs2 !== exp_s2(j)) begin
        n_fail++;
        $display("FAIL after_clr j=%0d: got %h expected %h", j, obs2, exp_s2(j));
      end
      tick();
    end
    iv2 = 1'b0;
  endtask

  // flush alone advances; flush with in_valid advances once
  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 256; k++) begin
      iv2 = (k >= 128);
      fl2 = 1'b1;
      tick();
    end
    iv2 = 1'b0;
    for (int k = 256; k < 262; k++) begin
      fl2 = 1'b1;
      #2;
      n_checks++;
      if (obs2 !== exp_s2(k)) begin
        n_fail++;
        $display("FAIL flush k=%0d: got %h expected %h", k, obs2, exp_s2(k));
      end
      tick();
    end
    fl2 = 1'b0;
  endtask

  // D=1 instance over two frames, then asynchronous reset mid-frame
  task automatic test_stage10();
    do_reset();
    for (int k = 0; k < 2048 + 5; k++) begin
      iv10 = 1'b1;
      #2;
      n_checks++;
      if (obs10 !== exp_s10(k)) begin
        n_fail++;
        $display("FAIL s10 k=%0d: got %h expected %h", k, obs10, exp_s10(k));
      end
      tick();
    end
    // Sample 2053 is a BFLY output; pull reset between edges
    iv10 = 1'b1;
    iv2  = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs10 !== 14'd0) begin
      n_fail++;
      $display("FAIL async_reset_s10: got %h expected %h", obs10, 14'd0);
    end
    n_checks++;
    if (obs2 !== 14'd0) begin
      n_fail++;
      $display("FAIL async_reset_s2: got %h expected %h", obs2, 14'd0);
    end
    tick();
    rst_n = 1'b1;
    // First sample after reset is an idle fill again
    #2;
    n_checks++;
    if (obs10 !== exp_s10(0)) begin
      n_fail++;
      $display("FAIL s10_after_reset: got %h expected %h", obs10, exp_s10(0));
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_frames();
    test_gaps();
    test_clr();
    test_flush();
    test_stage10();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
